dds_addr_gen_mc: RTL
====================

// Module: dds_addr_gen_mc
// PURPOSE
//  Multi-channel DDS phase accumulator and ROM address generator. Successor to the fixed single-channel sawtooth
//  address block: one accumulator per channel, frequency/phase/waveform programmable at run time, glitch-free
//  updates through shadow registers. Sits between the control/register interface and the per-channel waveform ROMs.
// PARAMETERS
//  NCH      2       number of independent channels (1..8)
//  ACC_W    32      phase accumulator width
//  ADDR_W   8       ROM address width per channel (ADDR_W < ACC_W, >= 2)
//  FW_RST   429497  frequency word loaded at reset (5 kHz at 50 MHz clk, ACC_W=32)
//  PW_RST   128     phase offset loaded at reset, in ROM-address units
//  UPD_WRAP 1       1: commit at channel wrap; 0: commit on next cycle after upd
// PORTS
//  clk       in   1             system clock
//  rst_n     in   1             asynchronous active-low reset
//  en        in   1             accumulate enable (all channels)
//  sync_clr  in   1             synchronous clear of all accumulators
//  cfg_we    in   1             config write strobe
//  cfg_ch    in   3             target channel
//  cfg_sel   in   2             0=FWORD 1=PWORD 2=MODE 3=reserved
//  cfg_data  in   ACC_W         write data (PWORD uses [ADDR_W-1:0], MODE uses [1:0])
//  cfg_err   out  1             1-cycle pulse: write to cfg_ch>=NCH or cfg_sel=3
//  upd       in   1             request commit of shadow regs, all channels
//  upd_busy  out  NCH           per-channel commit pending
//  addr_out  out  NCH*ADDR_W    ROM addresses, ch0 in LSBs
//  wrap      out  NCH           1-cycle pulse on accumulator carry-out
// BEHAVIOUR
//  Reset: acc=0, active and shadow FW=FW_RST, PW=PW_RST, MODE=0. addr_out=PW_RST per channel. wrap=0, upd_busy=0, cfg_err=0.
//  Accumulator, per channel, each clk:
//   sync_clr: acc<=0, wrap<=0. Takes priority over en.
//   else if en: {carry,acc} <= acc + FW_active, modulo 2^ACC_W. wrap<=carry.
//   else: acc and addr_out hold, wrap<=0.
//  Address map (registered, one cycle behind acc): p = acc[ACC_W-1 -: ADDR_W] + PW_active, mod 2^ADDR_W.
//   MODE 0 saw up: p.  MODE 1 saw down: ~p.
//   MODE 2 triangle: t={p[ADDR_W-2:0],1'b0}; p[MSB]=0 -> t, else ~t.
//   MODE 3 square: p[MSB]=0 -> all ones, else 0.
//  Config: cfg_we writes the shadow reg only; it never alters the active reg directly. cfg_err is registered.
//   An invalid write changes nothing.
//  Commit: upd sets upd_busy for all channels.
//   UPD_WRAP=0: the next cycle copies shadow to active and clears busy.
//   UPD_WRAP=1: a busy channel commits in the cycle its wrap carry occurs, so the new FW/PW/MODE
//    takes effect from phase 0. sync_clr also commits all busy channels immediately.
//   FW=0 with UPD_WRAP=1 never wraps. upd_busy stays set until sync_clr.
//  Simultaneous events:
//   cfg_we and commit in the same cycle: the commit uses the old shadow value and the new write stays
//    pending in shadow.
//   upd while busy: no effect, no extra commit.
//  Reset mid-operation: all state returns to reset values asynchronously, and pending commits are discarded.
// STRUCTURE
//  Package dds_pkg: MODE_SAW_UP/DN/TRI/SQR encodings, CFG_SEL_FW/PW/MODE constants.
//  Sub-module dds_chan: one accumulator, shadow/active regs, address map and wrap.
//   Instantiated NCH times by generate.
//  The top level decodes cfg writes, drives cfg_err, and concatenates the outputs.
// TESTING
//  Reset with NCH=2, ACC_W=12, ADDR_W=8, FW=16, PW=0 -> ch0 addr_out 0,1,2,...,255,0.
//   wrap pulses once every 256 cycles.
//  MODE sweep at FW=16:
//   MODE1 -> 255,254,...
//   MODE2 -> 0,2,...,254,255,253,...
//   MODE3 -> 255 for 128 cycles, then 0 for 128 cycles.
//  PW=64 written plus upd with UPD_WRAP=0 -> addr_out jumps by +64 exactly 2 cycles after upd.
//   ch1 is unaffected.
//  UPD_WRAP=1, FW changed 16->32 at acc=0x800 -> output keeps step 1 until wrap, then step 2 from address 0.
//   upd_busy clears with the wrap.
//  cfg_ch=3 or cfg_sel=3 -> cfg_err pulses one cycle and no register changes.
//   Also: cfg_we and commit in the same cycle -> old value committed, new value committed on the next upd.
//  sync_clr and en together mid-sweep -> addr_out=PW next cycle. en=0 -> outputs frozen.
//   rst_n low mid-run -> immediate reset values.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared encodings for the multi-channel DDS address generator.
package dds_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_SAW_UP = 2'd0;
  localparam mode_t MODE_SAW_DN = 2'd1;
  localparam mode_t MODE_TRI    = 2'd2;
  localparam mode_t MODE_SQR    = 2'd3;

  localparam logic [1:0] CFG_SEL_FW   = 2'd0;
  localparam logic [1:0] CFG_SEL_PW   = 2'd1;
  localparam logic [1:0] CFG_SEL_MODE = 2'd2;
  localparam logic [1:0] CFG_SEL_RSVD = 2'd3;

endpackage

// File: rtl/dds_chan.sv
// One DDS channel: phase accumulator, shadow/active config registers, waveform address map.
module dds_chan
  import dds_pkg::*;
#(
  parameter int unsigned ACC_W    = 32,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned FW_RST   = 429497,
  parameter int unsigned PW_RST   = 128,
  parameter int unsigned UPD_WRAP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sync_clr,
  input  logic              wr_fw,
  input  logic              wr_pw,
  input  logic              wr_mode,
  input  logic [ACC_W-1:0]  wr_data,
  input  logic              upd,
  output logic [ADDR_W-1:0] addr,
  output logic              wrap,
  output logic              upd_busy
);

  localparam logic [ACC_W-1:0]  FwRst = ACC_W'(FW_RST);
  localparam logic [ADDR_W-1:0] PwRst = ADDR_W'(PW_RST);

  logic [ACC_W-1:0]  acc_q, acc_d, fw_a_q, fw_a_d, fw_s_q, fw_s_d;
  logic [ADDR_W-1:0] pw_a_q, pw_a_d, pw_s_q, pw_s_d, addr_q, addr_d;
  mode_t             mode_a_q, mode_a_d, mode_s_q, mode_s_d;
  logic              wrap_q, wrap_d, busy_q, busy_d;
  logic [ACC_W:0]    sum;
  logic              carry, commit;

  function automatic logic [ADDR_W-1:0] map_addr(input logic [ADDR_W-1:0] ph,
                                                 input logic [ADDR_W-1:0] pw,
                                                 input mode_t             mode);
    logic [ADDR_W-1:0] p, t;
    p = ph + pw;
    t = {p[ADDR_W-2:0], 1'b0};
    map_addr = p;
    unique case (mode)
      MODE_SAW_UP: map_addr = p;
      MODE_SAW_DN: map_addr = ~p;
      MODE_TRI:    map_addr = p[ADDR_W-1] ? ~t : t;
      MODE_SQR:    map_addr = p[ADDR_W-1] ? '0 : '1;
    endcase
  endfunction

  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, fw_a_q};
    carry = sum[ACC_W];

    // Wrap-synchronous commit lets new settings start exactly at phase 0.
    if (UPD_WRAP != 0) commit = busy_q & (sync_clr | (en & carry));
    else               commit = busy_q;

    fw_a_d   = commit ? fw_s_q   : fw_a_q;
    pw_a_d   = commit ? pw_s_q   : pw_a_q;
    mode_a_d = commit ? mode_s_q : mode_a_q;
    busy_d   = busy_q ? ~commit : upd;

    fw_s_d   = wr_fw   ? wr_data              : fw_s_q;
    pw_s_d   = wr_pw   ? wr_data[ADDR_W-1:0]  : pw_s_q;
    mode_s_d = wr_mode ? mode_t'(wr_data[1:0]) : mode_s_q;

    acc_d  = acc_q;
    addr_d = addr_q;
    wrap_d = 1'b0;
    if (sync_clr) begin
      acc_d  = '0;
      addr_d = map_addr('0, pw_a_d, mode_a_d);
    end else if (en) begin
      acc_d  = sum[ACC_W-1:0];
      wrap_d = carry;
      addr_d = map_addr(acc_q[ACC_W-1 -: ADDR_W], pw_a_q, mode_a_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      fw_a_q   <= FwRst;
      fw_s_q   <= FwRst;
      pw_a_q   <= PwRst;
      pw_s_q   <= PwRst;
      mode_a_q <= MODE_SAW_UP;
      mode_s_q <= MODE_SAW_UP;
      addr_q   <= PwRst;
      wrap_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      fw_a_q   <= fw_a_d;
      fw_s_q   <= fw_s_d;
      pw_a_q   <= pw_a_d;
      pw_s_q   <= pw_s_d;
      mode_a_q <= mode_a_d;
      mode_s_q <= mode_s_d;
      addr_q   <= addr_d;
      wrap_q   <= wrap_d;
      busy_q   <= busy_d;
    end
  end

  assign addr     = addr_q;
  assign wrap     = wrap_q;
  assign upd_busy = busy_q;

endmodule

// File: rtl/dds_addr_gen_mc.sv
// Multi-channel DDS phase accumulator and ROM address generator: config decode plus NCH channels.
module dds_addr_gen_mc
  import dds_pkg::*;
#(
  parameter int unsigned NCH      = 2,
  parameter int unsigned ACC_W    = 32,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned FW_RST   = 429497,
  parameter int unsigned PW_RST   = 128,
  parameter int unsigned UPD_WRAP = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  sync_clr,
  input  logic                  cfg_we,
  input  logic [2:0]            cfg_ch,
  input  logic [1:0]            cfg_sel,
  input  logic [ACC_W-1:0]      cfg_data,
  output logic                  cfg_err,
  input  logic                  upd,
  output logic [NCH-1:0]        upd_busy,
  output logic [NCH*ADDR_W-1:0] addr_out,
  output logic [NCH-1:0]        wrap
);

  logic cfg_bad, cfg_ok, cfg_err_q;

  assign cfg_bad = ({1'b0, cfg_ch} >= 4'(NCH)) || (cfg_sel == CFG_SEL_RSVD);
  assign cfg_ok  = cfg_we & ~cfg_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg_err_q <= 1'b0;
    else        cfg_err_q <= cfg_we & cfg_bad;
  end

  assign cfg_err = cfg_err_q;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    logic hit;
    assign hit = cfg_ok && (cfg_ch == 3'(g));

    dds_chan #(
      .ACC_W    (ACC_W),
      .ADDR_W   (ADDR_W),
      .FW_RST   (FW_RST),
      .PW_RST   (PW_RST),
      .UPD_WRAP (UPD_WRAP)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .sync_clr (sync_clr),
      .wr_fw    (hit && (cfg_sel == CFG_SEL_FW)),
      .wr_pw    (hit && (cfg_sel == CFG_SEL_PW)),
      .wr_mode  (hit && (cfg_sel == CFG_SEL_MODE)),
      .wr_data  (cfg_data),
      .upd      (upd),
      .addr     (addr_out[g*ADDR_W +: ADDR_W]),
      .wrap     (wrap[g]),
      .upd_busy (upd_busy[g])
    );
  end

endmodule
